// File: rtl/move_collector.sv
// Collects eligible moves from the 64-square move-generation array after it settles
// and streams them one per cycle over a valid/ready handshake.
module move_collector #(
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              engine_color,
  output logic [5:0]        sq_sel,
  input  logic [87:0]       ray_in,
  input  logic [63:0]       knight_in,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [5:0]        move_from,
  output logic [5:0]        move_to,
  output logic [3:0]        move_dir,
  output logic              move_pawn,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  move_count
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t            r_state;
  logic [SET_W-1:0]  r_settle_cnt;
  logic              r_color;
  logic [15:0]       r_mask;
  logic [5:0]        r_sq_sel;
  logic              r_move_valid;
  logic [5:0]        r_move_from;
  logic [5:0]        r_move_to;
  logic [3:0]        r_move_dir;
  logic              r_move_pawn;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_move_count;
  logic [7:0][10:0]  r_ray_words;
  logic [7:0][7:0]   r_kn_words;

  logic [7:0][10:0]  w_ray_in;
  logic [7:0][7:0]   w_kn_in;
  logic [15:0]       w_elig;
  logic [3:0]        w_slot;
  logic              w_any;
  logic [15:0]       w_mask_next;
  logic [5:0]        w_from;
  logic              w_pawn;
  logic              w_take;
  logic              w_accept;

  assign w_ray_in = ray_in;
  assign w_kn_in  = knight_in;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < 8; i++) begin
      w_elig[i]     = w_ray_in[i][7] && (w_ray_in[i][10] == r_color);
      w_elig[i + 8] = w_kn_in[i][6]  && (w_kn_in[i][7]   == r_color);
    end
  end

  // Lowest pending slot wins: ray slots before knight slots.
  always_comb begin
    w_slot = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_mask[i]) w_slot = 4'(i);
    end
  end

  assign w_any       = |r_mask;
  assign w_mask_next = r_mask & ~(16'd1 << w_slot);
  assign w_from      = w_slot[3] ? r_kn_words[w_slot[2:0]][5:0] : r_ray_words[w_slot[2:0]][5:0];
  assign w_pawn      = !w_slot[3] && r_ray_words[w_slot[2:0]][6];
  // The output register may be reloaded when empty or when its move is being taken.
  assign w_take      = !r_move_valid || move_ready;
  assign w_accept    = r_move_valid && move_ready;

  // NOTE: the captured words are pure data qualified by r_mask, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_ray_words <= w_ray_in;
      r_kn_words  <= w_kn_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_color      <= 1'b0;
      r_mask       <= '0;
      r_sq_sel     <= '0;
      r_move_valid <= 1'b0;
      r_move_from  <= '0;
      r_move_to    <= '0;
      r_move_dir   <= '0;
      r_move_pawn  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_move_count <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_color      <= engine_color;
            r_move_count <= '0;
            r_busy       <= 1'b1;
            r_settle_cnt <= '0;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (int'(r_settle_cnt) + 1 >= SETTLE_CYCLES) begin
            r_sq_sel <= '0;
            r_state  <= S_LOAD;
          end else begin
            r_settle_cnt <= r_settle_cnt + SET_W'(1);
          end
        end
        S_LOAD: begin
          r_mask  <= w_elig;
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (w_accept && (r_move_count != '1)) r_move_count <= r_move_count + 1'b1;
          if (w_take) begin
            if (w_any) begin
              r_move_valid <= 1'b1;
              r_mask       <= w_mask_next;
              r_move_from  <= w_from;
              r_move_to    <= r_sq_sel;
              r_move_dir   <= w_slot;
              r_move_pawn  <= w_pawn;
            end else begin
              // Square drained; advancing on the final accept avoids a bubble cycle.
              r_move_valid <= 1'b0;
              if (r_sq_sel == 6'd63) begin
                r_state <= S_DONE;
              end else begin
                r_sq_sel <= r_sq_sel + 6'd1;
                r_state  <= S_LOAD;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sq_sel     = r_sq_sel;
  assign move_valid = r_move_valid;
  assign move_from  = r_move_from;
  assign move_to    = r_move_to;
  assign move_dir   = r_move_dir;
  assign move_pawn  = r_move_pawn;
  assign busy       = r_busy;
  assign done       = r_done;
  assign move_count = r_move_count;

endmodule

// File: doc/move_collector.md
Name: move_collector

Overview:
- Sits directly downstream of the 64 per-square transceivers in the move-generation array.
- After the array settles, scans squares 0..63 via a square-select mux and reads each square's 8 registered ray-move words and 8 knight-move words.
- Drops words that are invalid or belong to the non-engine colour.
- Serialises the survivors as one move per cycle on a valid/ready stream to the search/evaluation stage.

Parameters:
- SETTLE_CYCLES, 8, clocks waited after start before scanning; covers worst-case 7-hop ray propagation plus one register.
- CNT_W, 8, width of move_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin a generation pass; ignored unless IDLE
- engine_color  in  1  colour whose moves are collected (sampled on accepted start)
- sq_sel  out  6  square index driven to the external array mux
- ray_in  in  88  selected square's ray words, 11 bits each; slot 0..7 = U,D,L,R,UL,UR,DL,DR
- knight_in  in  64  selected square's knight words, 8 bits each; slot 0..7 = UUL,UUR,LLU,RRU,DDL,DDR,LLD,RRD
- move_valid  out  1  move_* fields hold a move
- move_ready  in  1  consumer accepts the move when high with move_valid
- move_from  out  6  origin square
- move_to  out  6  destination square (= square being drained)
- move_dir  out  4  0..7 ray slots, 8..15 knight slots
- move_pawn  out  1  pawn flag of the ray word; 0 for knight moves
- busy  out  1  high from accepted start until the done cycle
- done  out  1  one-cycle pulse at end of pass
- move_count  out  CNT_W  moves accepted this pass; held after done

Behaviour:
- Word formats (fixed):
  - Ray word: [10] colour, [9] orthogonal slider, [8] diagonal slider, [7] valid, [6] pawn, [5:0] origin.
  - Knight word: [7] colour, [6] valid, [5:0] origin.
  - A slot is eligible when valid=1 and colour=engine_color.
- Reset: state IDLE; sq_sel=0, move_valid=0, move_from/to/dir/pawn=0, busy=0, done=0, move_count=0, pending mask=0, settle counter=0.
- States: IDLE, SETTLE, LOAD, EMIT, DONE.
- IDLE:
  - On start, latch engine_color, clear move_count, set busy, go to SETTLE.
  - start in any other state is ignored.
- SETTLE:
  - Counts SETTLE_CYCLES clocks, then sets sq_sel=0 and goes to LOAD.
  - SETTLE_CYCLES=0 goes to LOAD on the next cycle.
- LOAD:
  - sq_sel is stable for the whole cycle; the mux is combinational.
  - At the clock edge, capture a 16-bit pending mask (bit i = slot i eligible) and all 16 words. Go to EMIT.
- EMIT:
  - If the mask is non-zero, present the lowest set slot: move_valid=1, fields registered from the captured word, move_to=sq_sel.
  - On move_valid && move_ready: clear that bit, increment move_count, and present the next set slot on the following cycle. Result: back-to-back acceptance of one move per cycle with no bubble.
  - While move_ready is low, move_valid and all fields stay stable.
  - When the mask is zero and no move is outstanding: move_valid=0.
    - If sq_sel=63, go to DONE.
    - Otherwise sq_sel+1 and go to LOAD.
- Cycle cost per square: empty square = 2 cycles (LOAD + EMIT check); square with k eligible moves under constant ready = 2 + k.
- DONE: done=1 for one cycle, busy=0, go to IDLE. move_count is held until the next accepted start.
- move_count saturates at 2^CNT_W−1; the legal maximum of 218 never reaches it at default width.
- Inputs are sampled only in LOAD; array changes afterwards do not affect the current square.
- Reset asserted mid-pass: immediate return to reset values. No done pulse; the partial count is discarded.

Test Plan:
1. All words zero, start, SETTLE_CYCLES=8, ready=1 → no move_valid; done pulses exactly 8+1+128 cycles after start is sampled; move_count=0; sq_sel visits 0..63 in order.
2. Square 20 has U word 11'b1_0_0_1_0_001100 and knight UUL 8'b1_1_000101; engine_color=1; ready=1 → two consecutive moves at sq 20: (from 12, to 20, dir 0, pawn 0), then (from 5, to 20, dir 8); move_count=2.
3. Same as 2 with engine_color=0 → no moves emitted; move_count=0.
4. Square 35 has DL pawn word 11'b0_0_0_1_1_101010; engine_color=0; ready held low 5 cycles → move_valid stays high and fields stay stable for 5 cycles; accepted on the first ready=1 cycle; from=42, pawn=1, dir=6.
5. start pulsed while busy → ignored; count and timing identical to a single pass.
6. rst_n driven low while EMIT is holding a move with ready=0 → move_valid=0, busy=0, sq_sel=0 asynchronously. A new start after release runs a full clean pass.
